// File: rtl/mem_arbiter.sv
// Two-port cache-line arbiter: an icache read port and a dcache read/writeback
// port share one memory port, with round-robin on ties and one IDLE cycle between transactions.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_dfp_addr,
  input  logic                  i_dfp_read,
  output logic [LINE_WIDTH-1:0] i_dfp_rdata,
  output logic                  i_dfp_resp,
  input  logic [ADDR_WIDTH-1:0] d_dfp_addr,
  input  logic                  d_dfp_read,
  input  logic                  d_dfp_write,
  input  logic [LINE_WIDTH-1:0] d_dfp_wdata,
  output logic [LINE_WIDTH-1:0] d_dfp_rdata,
  output logic                  d_dfp_resp,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  output logic                  idle,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t state;
  state_t view;
  logic   last_grant;
  logic   i_req;
  logic   d_req;

  assign i_req = i_dfp_read;
  assign d_req = d_dfp_read | d_dfp_write;

  // last_grant = 1 means dcache was served last, so an icache/dcache tie goes to icache.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i_req && (!d_req || last_grant)) begin
            state      <= GRANT_I;
            last_grant <= 1'b0;
          end else if (d_req) begin
            state      <= GRANT_D;
            last_grant <= 1'b1;
          end
        end
        GRANT_I: if (mem_resp) state <= IDLE;
        GRANT_D: if (mem_resp) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Reset forces the IDLE view so an aborted grant never leaks strobes or responses.
  assign view      = rst ? IDLE : state;
  assign idle      = (view == IDLE);
  assign state_dbg = view;

  always_comb begin
    mem_addr    = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_wdata   = '0;
    i_dfp_rdata = '0;
    i_dfp_resp  = 1'b0;
    d_dfp_rdata = '0;
    d_dfp_resp  = 1'b0;
    case (view)
      GRANT_I: begin
        mem_addr    = i_dfp_addr;
        mem_read    = i_dfp_read;
        i_dfp_rdata = mem_rdata;
        i_dfp_resp  = mem_resp;
      end
      GRANT_D: begin
        mem_addr    = d_dfp_addr;
        mem_wdata   = d_dfp_wdata;
        mem_write   = d_dfp_write;
        mem_read    = d_dfp_read & ~d_dfp_write;
        d_dfp_rdata = mem_rdata;
        d_dfp_resp  = mem_resp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a per-cycle vector table for the directed scenarios,
// then a scoreboarded fairness run against a randomised-latency memory model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int W  = LW + 1;

  localparam logic [LW-1:0] PAT_A = {32{8'hAA}};
  localparam logic [LW-1:0] PAT_5 = {32{8'h55}};

  // Handshake: a requester raises read/write with a stable address and holds it
  // until its resp pulses for one cycle; memory answers with mem_resp + mem_rdata.

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] i_dfp_addr = '0;
  logic          i_dfp_read = 1'b0;
  logic [LW-1:0] i_dfp_rdata;
  logic          i_dfp_resp;
  logic [AW-1:0] d_dfp_addr = '0;
  logic          d_dfp_read = 1'b0;
  logic          d_dfp_write = 1'b0;
  logic [LW-1:0] d_dfp_wdata = '0;
  logic [LW-1:0] d_dfp_rdata;
  logic          d_dfp_resp;
  logic [AW-1:0] mem_addr;
  logic          mem_read;
  logic          mem_write;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata = '0;
  logic          mem_resp = 1'b0;
  logic          idle;
  logic [1:0]    state_dbg;

  mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .i_dfp_addr(i_dfp_addr), .i_dfp_read(i_dfp_read),
    .i_dfp_rdata(i_dfp_rdata), .i_dfp_resp(i_dfp_resp),
    .d_dfp_addr(d_dfp_addr), .d_dfp_read(d_dfp_read), .d_dfp_write(d_dfp_write),
    .d_dfp_wdata(d_dfp_wdata), .d_dfp_rdata(d_dfp_rdata), .d_dfp_resp(d_dfp_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .idle(idle), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          rst;
    logic          i_rd;
    logic [AW-1:0] i_addr;
    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_wdata;
    logic          m_resp;
    logic          e_idle;
    logic          e_mrd;
    logic          e_mwr;
    logic [AW-1:0] e_maddr;
    logic [LW-1:0] e_mwdata;
    logic          e_iresp;
    logic          e_dresp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic ird, input logic [AW-1:0] ia,
                     input logic drd, input logic dwr, input logic [AW-1:0] da,
                     input logic [LW-1:0] dw, input logic mr,
                     input logic e_idle, input logic e_mrd, input logic e_mwr,
                     input logic [AW-1:0] e_ma, input logic [LW-1:0] e_mw,
                     input logic e_ir, input logic e_dr);
    vec_t v;
    v.rst = r; v.i_rd = ird; v.i_addr = ia; v.d_rd = drd; v.d_wr = dwr;
    v.d_addr = da; v.d_wdata = dw; v.m_resp = mr;
    v.e_idle = e_idle; v.e_mrd = e_mrd; v.e_mwr = e_mwr; v.e_maddr = e_ma;
    v.e_mwdata = e_mw; v.e_iresp = e_ir; v.e_dresp = e_dr;
    vecs.push_back(v);
  endtask

  // Driver: apply one vector just after the rising edge.
  task automatic drive_vec(input vec_t v);
    rst         = v.rst;
    i_dfp_read  = v.i_rd;
    i_dfp_addr  = v.i_addr;
    d_dfp_read  = v.d_rd;
    d_dfp_write = v.d_wr;
    d_dfp_addr  = v.d_addr;
    d_dfp_wdata = v.d_wdata;
    mem_resp    = v.m_resp;
    mem_rdata   = v.m_resp ? PAT_A : '0;
  endtask

  // Scoreboard: {who (1 = dcache), line data} in expected completion order.
  logic [W-1:0] exp_q[$];

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    return {8{a}};
  endfunction

  initial begin
    logic [W-1:0] ctl_act, ctl_exp, got, want;
    logic [AW-1:0] ia, da;
    int ni, nd, wait_cnt, cyc;
    logic seen_i, seen_d;

    //  rst ird iaddr     drd dwr daddr     wdata  mr | idl mrd mwr maddr     mwdata ir dr
    add(1, 1, 32'h1000, 0, 0, 32'h0,    '0,    1,   1, 0, 0, 32'h0,    '0,    0, 0); // in reset
    add(1, 0, 32'h0,    0, 0, 32'h0,    '0,    0,   1, 0, 0, 32'h0,    '0,    0, 0);
    add(0, 0, 32'h0,    0, 0, 32'h0,    '0,    0,   1, 0, 0, 32'h0,    '0,    0, 0); // first cycle after
    add(0, 0, 32'h0,    0, 0, 32'h0,    '0,    1,   1, 0, 0, 32'h0,    '0,    0, 0); // stray resp in IDLE
    add(0, 0, 32'h0,    0, 0, 32'h0,    '0,    0,   1, 0, 0, 32'h0,    '0,    0, 0);
    add(0, 1, 32'h1000, 0, 0, 32'h0,    '0,    0,   1, 0, 0, 32'h0,    '0,    0, 0); // icache read
    add(0, 1, 32'h1000, 0, 0, 32'h0,    '0,    0,   0, 1, 0, 32'h1000, '0,    0, 0);
    add(0, 1, 32'h1000, 0, 0, 32'h0,    '0,    0,   0, 1, 0, 32'h1000, '0,    0, 0);
    add(0, 1, 32'h1000, 0, 0, 32'h0,    '0,    0,   0, 1, 0, 32'h1000, '0,    0, 0);
    add(0, 1, 32'h1000, 0, 0, 32'h0,    '0,    1,   0, 1, 0, 32'h1000, '0,    1, 0);
    add(0, 0, 32'h0,    0, 0, 32'h0,    '0,    0,   1, 0, 0, 32'h0,    '0,    0, 0);
    add(0, 0, 32'h0,    1, 1, 32'h2000, PAT_5, 0,   1, 0, 0, 32'h0,    '0,    0, 0); // writeback
    add(0, 0, 32'h0,    1, 1, 32'h2000, PAT_5, 0,   0, 0, 1, 32'h2000, PAT_5, 0, 0);
    add(0, 0, 32'h0,    1, 1, 32'h2000, PAT_5, 1,   0, 0, 1, 32'h2000, PAT_5, 0, 1);
    add(0, 0, 32'h0,    0, 0, 32'h0,    '0,    0,   1, 0, 0, 32'h0,    '0,    0, 0);
    add(0, 0, 32'h0,    1, 0, 32'h3000, '0,    0,   1, 0, 0, 32'h0,    '0,    0, 0); // reset mid-D
    add(0, 0, 32'h0,    1, 0, 32'h3000, '0,    0,   0, 1, 0, 32'h3000, '0,    0, 0);
    add(1, 0, 32'h0,    1, 0, 32'h3000, '0,    0,   1, 0, 0, 32'h0,    '0,    0, 0);
    add(0, 0, 32'h0,    0, 0, 32'h0,    '0,    1,   1, 0, 0, 32'h0,    '0,    0, 0);
    add(0, 1, 32'h4000, 1, 0, 32'h5000, '0,    0,   1, 0, 0, 32'h0,    '0,    0, 0); // tie
    add(0, 1, 32'h4000, 1, 0, 32'h5000, '0,    0,   0, 1, 0, 32'h4000, '0,    0, 0);
    add(0, 1, 32'h4000, 1, 0, 32'h5000, '0,    1,   0, 1, 0, 32'h4000, '0,    1, 0);
    add(0, 0, 32'h0,    1, 0, 32'h5000, '0,    0,   1, 0, 0, 32'h0,    '0,    0, 0);
    add(0, 0, 32'h0,    1, 0, 32'h5000, '0,    0,   0, 1, 0, 32'h5000, '0,    0, 0);
    add(0, 0, 32'h0,    1, 0, 32'h5000, '0,    1,   0, 1, 0, 32'h5000, '0,    0, 1);
    add(0, 0, 32'h0,    0, 0, 32'h0,    '0,    0,   1, 0, 0, 32'h0,    '0,    0, 0);
    add(0, 1, 32'h6000, 0, 0, 32'h0,    '0,    0,   1, 0, 0, 32'h0,    '0,    0, 0); // drop req in grant
    add(0, 0, 32'h6000, 0, 0, 32'h0,    '0,    0,   0, 0, 0, 32'h6000, '0,    0, 0);
    add(0, 0, 32'h6000, 0, 0, 32'h0,    '0,    1,   0, 0, 0, 32'h6000, '0,    1, 0);
    add(0, 0, 32'h0,    0, 0, 32'h0,    '0,    0,   1, 0, 0, 32'h0,    '0,    0, 0);

    foreach (vecs[k]) begin
      @(posedge clk); #1;
      drive_vec(vecs[k]);
      @(negedge clk);
      ctl_act = W'({idle, mem_read, mem_write, i_dfp_resp, d_dfp_resp, mem_addr});
      ctl_exp = W'({vecs[k].e_idle, vecs[k].e_mrd, vecs[k].e_mwr,
                    vecs[k].e_iresp, vecs[k].e_dresp, vecs[k].e_maddr});
      check($sformatf("v%0d_ctl", k), ctl_act, ctl_exp);
      check($sformatf("v%0d_mwdata", k), W'(mem_wdata), W'(vecs[k].e_mwdata));
      check($sformatf("v%0d_irdata", k), W'(i_dfp_rdata), vecs[k].e_iresp ? W'(PAT_A) : '0);
      check($sformatf("v%0d_drdata", k), W'(d_dfp_rdata), vecs[k].e_dresp ? W'(PAT_A) : '0);
    end

    // Fairness run: both ports re-request for two lines each; expect I, D, I, D.
    @(posedge clk); #1;
    rst = 1'b1; mem_resp = 1'b0; mem_rdata = '0;
    i_dfp_read = 1'b0; d_dfp_read = 1'b0; d_dfp_write = 1'b0; d_dfp_wdata = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    ia = 32'h100; da = 32'h200;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({1'b0, line_of(ia + AW'(4 * k))});
      exp_q.push_back({1'b1, line_of(da + AW'(4 * k))});
    end
    i_dfp_addr = ia; i_dfp_read = 1'b1;
    d_dfp_addr = da; d_dfp_read = 1'b1;
    ni = 0; nd = 0; cyc = 0;
    seen_i = 1'b0; seen_d = 1'b0;
    wait_cnt = $urandom_range(1, 3);
    while ((ni < 2 || nd < 2) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      mem_resp = 1'b0; mem_rdata = '0;
      if (seen_i) begin
        ni++; ia = ia + 4; i_dfp_addr = ia;
        if (ni == 2) i_dfp_read = 1'b0;
      end
      if (seen_d) begin
        nd++; da = da + 4; d_dfp_addr = da;
        if (nd == 2) d_dfp_read = 1'b0;
      end
      #1;
      // Memory model: answer after a random number of strobed cycles.
      if (mem_read || mem_write) begin
        if (wait_cnt == 0) begin
          mem_resp  = 1'b1;
          mem_rdata = line_of(mem_addr);
          wait_cnt  = $urandom_range(1, 3);
        end else begin
          wait_cnt--;
        end
      end
      @(negedge clk);
      seen_i = i_dfp_resp;
      seen_d = d_dfp_resp;
      if (i_dfp_resp || d_dfp_resp) begin
        got = {d_dfp_resp, d_dfp_resp ? d_dfp_rdata : i_dfp_rdata};
        if (i_dfp_resp && d_dfp_resp) got = '1;
        if (exp_q.size() == 0) begin
          check("sb_underflow", got, '0);
          seen_i = 1'b0; seen_d = 1'b0;
        end else begin
          want = exp_q.pop_front();
          check($sformatf("sb_resp_i%0d_d%0d", ni, nd), got, want);
        end
      end
    end
    check("sb_timeout", W'(cyc >= 200), '0);
    check("sb_left", W'(exp_q.size()), '0);

    @(posedge clk); #1;
    i_dfp_read = 1'b0; d_dfp_read = 1'b0; mem_resp = 1'b0;
    @(negedge clk);
    check("final_idle", W'(idle), W'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
